// File: rtl/pre_emphasis_pkg.sv
// Shared types and constants for the multi-channel pre-emphasis filter.
package pre_emphasis_pkg;

    localparam int ALPHA_Q15_DEFAULT = 31785;

    // Upper bounds for the pipeline-stage payload; instances use the low bits.
    localparam int MAX_DATA_W = 64;
    localparam int MAX_CH_W   = 16;

    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                         valid;
        logic [MAX_CH_W-1:0]          ch;
        logic signed [MAX_DATA_W-1:0] data;
        logic                         bypass;
    } stage_t;

endpackage

// File: rtl/pre_emph_limit.sv
// Reduces the widened difference to the output width: saturation when
// PRE_EMPHASIS_SAT_EN is defined, two's-complement wrap otherwise.
module pre_emph_limit #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

`ifdef PRE_EMPHASIS_SAT_EN
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        dout = din[OUT_W-1:0];
        if (din > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
        end else if (din < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
        end
    end
`else
    logic unused_hi;

    assign dout      = $signed(din[OUT_W-1:0]);
    assign unused_hi = ^din[IN_W-1:OUT_W];
`endif

endmodule

// File: rtl/pre_emphasis_mc.sv
// Time-multiplexed pre-emphasis filter y = x - alpha*x_prev[ch], 2-stage pipeline.
// Output limiting selected by PRE_EMPHASIS_SAT_EN (saturate) or wrap by default.
module pre_emphasis_mc
    import pre_emphasis_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  COEF_W = 16,
    parameter int  N_CH   = 4,
    localparam int CH_W   = ch_width(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [COEF_W-1:0] alpha,
    input  logic                     bypass,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic [CH_W-1:0]          s_ch,
    input  logic                     s_sof,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic [CH_W-1:0]          m_ch
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int DIFF_W = DATA_W + 2;

    logic signed [DATA_W-1:0] x_prev [N_CH];
    logic signed [DATA_W-1:0] prev_rd;
    logic signed [PROD_W-1:0] s1_prod;
    stage_t                   s1;

    logic                     advance;
    logic                     accept;
    logic signed [DATA_W-1:0] x2;
    logic signed [DIFF_W-1:0] sub2;
    logic signed [DIFF_W-1:0] diff2;
    logic signed [DATA_W-1:0] lim_out;
    logic                     unused_stage;

    assign advance = m_ready || !m_valid;
    assign s_ready = advance && !rst;
    assign accept  = s_valid && s_ready;

    // Out-of-range channels match no entry and therefore read zero history.
    always_comb begin
        prev_rd = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (s_ch == CH_W'(i)) begin
                prev_rd = x_prev[i];
            end
        end
        if (s_sof) begin
            prev_rd = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                x_prev[i] <= '0;
            end
            s1      <= '0;
            s1_prod <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= '0;
        end else begin
            if (accept) begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (s_ch == CH_W'(i)) begin
                        x_prev[i] <= s_data;
                    end
                end
            end
            if (advance) begin
                s1.valid <= accept;
                if (accept) begin
                    s1.ch     <= MAX_CH_W'(s_ch);
                    s1.data   <= MAX_DATA_W'(s_data);
                    s1.bypass <= bypass;
                    s1_prod   <= PROD_W'(alpha) * PROD_W'(prev_rd);
                end
                m_valid <= s1.valid;
                if (s1.valid) begin
                    m_data <= lim_out;
                    m_ch   <= s1.ch[CH_W-1:0];
                end
            end
        end
    end

    always_comb begin
        x2    = $signed(s1.data[DATA_W-1:0]);
        sub2  = DIFF_W'(s1_prod >>> (COEF_W - 1));
        diff2 = s1.bypass ? DIFF_W'(x2) : (DIFF_W'(x2) - sub2);
    end

    pre_emph_limit #(
        .IN_W  (DIFF_W),
        .OUT_W (DATA_W)
    ) u_limit (
        .din  (diff2),
        .dout (lim_out)
    );

    assign unused_stage = ^{s1.ch, s1.data};

endmodule

// File: tb/tb_pre_emphasis_mc.sv
// Scoreboard bench for pre_emphasis_mc with directed, hand-computed vectors.
module tb_pre_emphasis_mc;
    import pre_emphasis_pkg::*;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int N_CH   = 3;
    localparam int CH_W   = ch_width(N_CH);
    localparam int A      = ALPHA_Q15_DEFAULT;

`ifdef PRE_EMPHASIS_SAT_EN
    localparam int EXP_OVF = -32768;
`else
    localparam int EXP_OVF = 984;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic signed [COEF_W-1:0] alpha;
    logic                     bypass;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic [CH_W-1:0]          s_ch;
    logic                     s_sof;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic [CH_W-1:0]          m_ch;

    pre_emphasis_mc #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .N_CH   (N_CH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .alpha   (alpha),
        .bypass  (bypass),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_ch    (s_ch),
        .s_sof   (s_sof),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_ch    (m_ch)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          data;
        int          ch;
        int unsigned acc;
        bit          lat;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   saw_low;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic send(input int ch, input int x, input bit sof, input bit byp,
                        input int a, input int req, input bit lat, input bit push,
                        input string name);
        int unsigned tries = 0;
        exp_t e;
        @(negedge clk);
        s_valid = 1'b1;
        s_ch    = CH_W'(ch);
        s_data  = DATA_W'(x);
        s_sof   = sof;
        bypass  = byp;
        alpha   = COEF_W'(a);
        forever begin
            #1;
            if (s_ready) break;
            tries++;
            if (tries > 50) begin
                checks++;
                errors++;
                $display("FAIL %s_accept: s_ready stayed 0 for %0d cycles, required 1", name, tries);
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (push) begin
            e.data = req;
            e.ch   = ch;
            e.acc  = cyc;
            e.lat  = lat;
            e.name = name;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d outputs outstanding, required 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: pops expectations on each output handshake, checks stall holding.
    initial begin
        logic                     pv = 1'b0;
        logic                     pr = 1'b0;
        logic signed [DATA_W-1:0] pd = '0;
        logic [CH_W-1:0]          pc = '0;
        exp_t                     e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (pv && !pr) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, pd);
                    check("hold_ch", m_ch, pc);
                end
                if (m_valid && m_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got m_data %0d, required no output", m_data);
                    end else begin
                        e = sbq.pop_front();
                        check({e.name, "_data"}, m_data, e.data);
                        check({e.name, "_ch"}, m_ch, e.ch);
                        if (e.lat) check({e.name, "_latency"}, cyc - e.acc, 2);
                    end
                end
            end
            pv = rst ? 1'b0 : m_valid;
            pr = m_ready;
            pd = m_data;
            pc = m_ch;
        end
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_ch    = '0;
        s_sof   = 1'b0;
        bypass  = 1'b0;
        alpha   = COEF_W'(A);
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_m_valid", m_valid, 0);
        check("reset_m_data", m_data, 0);
        check("reset_m_ch", m_ch, 0);
        check("reset_s_ready", s_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        send(0, 1000, 0, 0, A, 1000, 1, 1, "basic0");
        send(0, 1000, 0, 0, A, 30,   1, 1, "basic1");

        send(0, 1000, 1, 0, A, 1000, 1, 1, "ilv0");
        send(1, 2000, 1, 0, A, 2000, 1, 1, "ilv1");
        send(0, 1000, 0, 0, A, 30,   1, 1, "ilv2");
        send(1, 2000, 0, 0, A, 60,   1, 1, "ilv3");

        send(1, -1000, 1, 0, A, -1000, 1, 1, "floor0");
        send(1, 0,     0, 0, A, 971,   1, 1, "floor1");

        send(0, 32767,  1, 0, A, 32767,   1, 1, "ovf0");
        send(0, -32768, 0, 0, A, EXP_OVF, 1, 1, "ovf1");

        send(0, 1000, 1, 0, A, 1000, 1, 1, "sof0");
        send(0, 1000, 1, 0, A, 1000, 1, 1, "sof1");
        send(0, 1234, 0, 1, A, 1234, 1, 1, "byp0");
        send(0, -5,   0, 1, A, -5,   1, 1, "byp1");
        send(0, 1000, 0, 0, A, 1005, 1, 1, "byp_hist");

        send(3, 500, 0, 0, A, 500,  1, 1, "oor0");
        send(3, 500, 0, 0, A, 500,  1, 1, "oor1");
        send(0, 0,   0, 0, A, -970, 1, 1, "oor_ch0");
        drain("directed");

        @(negedge clk);
        m_ready = 1'b0;
        saw_low = 1'b0;
        fork
            begin
                send(2, 100, 1, 0, 16384, 100, 0, 1, "stall0");
                send(2, 200, 0, 0, 16384, 150, 0, 1, "stall1");
                send(2, 300, 0, 0, 16384, 200, 0, 1, "stall2");
                send(2, 400, 0, 0, 16384, 250, 0, 1, "stall3");
                send(2, 500, 0, 0, 16384, 300, 0, 1, "stall4");
                send(2, 600, 0, 0, 16384, 350, 0, 1, "stall5");
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    if (!s_ready) saw_low = 1'b1;
                end
                check("stall_s_ready_now", s_ready, 0);
                check("stall_s_ready_dropped", saw_low, 1);
                @(negedge clk);
                m_ready = 1'b1;
            end
        join
        drain("stall");

        m_ready = 1'b0;
        send(0, 5000, 0, 0, A, 0, 0, 0, "inflight0");
        send(0, 5000, 0, 0, A, 0, 0, 0, "inflight1");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_s_ready", s_ready, 0);
        @(negedge clk);
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_data", m_data, 0);
        rst     = 1'b0;
        m_ready = 1'b1;
        send(0, 1000, 0, 0, A, 1000, 1, 1, "post_rst");
        drain("post_rst");

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pre_emphasis_mc.md
PRE_EMPHASIS_MC -- requirements
Module: pre_emphasis_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed sample width.
REQ-002 SHALL have parameter COEF_W, default 16, signed coefficient width, format Q1.(COEF_W-1).
REQ-003 SHALL have parameter N_CH, default 4, number of time-multiplexed channels (N_CH>=1); derived localparam CH_W = max(1, clog2(N_CH)).
REQ-004 SHALL have ports: clk, in, 1, sole clock; one clock domain, reset synchronous and active-high.
REQ-005 SHALL have port rst, in, 1, synchronous active-high reset.
REQ-006 SHALL have port alpha, in, COEF_W, pre-emphasis coefficient; default usage 31785 (0.97).
REQ-007 SHALL have port bypass, in, 1, pass-through mode (y = x).
REQ-008 SHALL have ports s_valid, in, 1 / s_ready, out, 1, input handshake.
REQ-009 SHALL have ports s_data, in, DATA_W signed / s_ch, in, CH_W / s_sof, in, 1 (start of frame: history treated as zero).
REQ-010 SHALL have ports m_valid, out, 1 / m_ready, in, 1, output handshake.
REQ-011 SHALL have ports m_data, out, DATA_W signed / m_ch, out, CH_W.

Function
REQ-012 SHALL compute per channel y[n] = x[n] - ((alpha * x_prev[ch]) >>> (COEF_W-1)), arithmetic shift (floor), full-width product DATA_W+COEF_W bits.
REQ-013 SHALL keep one DATA_W history register per channel; channels fully independent.
REQ-014 SHALL accept a sample on a cycle where s_valid && s_ready; alpha, bypass, s_sof, s_ch sampled at that edge and carried with the sample.
REQ-015 SHALL read x_prev[s_ch] and write s_data into x_prev[s_ch] on the accepting edge, so back-to-back samples of the same channel use correct history without bubbles.
REQ-016 SHALL use zero as x_prev for an accepted sample with s_sof=1; the history is still updated with s_data.
REQ-017 SHALL output y = x exactly when bypass=1; the history is still updated.
REQ-018 SHALL be a 2-stage pipeline (stage 1: multiply; stage 2: subtract/limit to m_data); latency 2 cycles accept-to-m_valid when unstalled; throughput 1 sample/cycle.
REQ-019 SHALL advance the whole pipeline when m_ready || !m_valid; s_ready equals that advance condition (combinational from m_ready and internal valids, never from s_valid).
REQ-020 SHALL hold m_data and m_ch stable while m_valid && !m_ready; no sample is dropped, duplicated or reordered.
REQ-021 SHALL give out-of-range s_ch (>= N_CH) no history update and output it with x_prev = 0.

Reset
REQ-022 SHALL clear all x_prev to 0, all pipeline valids to 0, m_valid=0, m_data=0, m_ch=0 on rst=1 at a clock edge.
REQ-023 SHALL discard in-flight samples on reset mid-stream; s_ready=0 while rst=1.

Configuration
REQ-024 SHALL, with macro PRE_EMPHASIS_SAT_EN defined, clamp the difference to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-025 SHALL, without PRE_EMPHASIS_SAT_EN, output the low DATA_W bits of the difference (two's-complement wrap).

Structure
REQ-026 SHALL place in shared package pre_emphasis_pkg: ALPHA_Q15_DEFAULT = 31785, the function computing CH_W, and the pipeline-stage struct typedef (valid, ch, data, bypass).
REQ-027 SHALL implement the limit step (saturate or wrap per REQ-024/025) as sub-module pre_emph_limit.

Verification
REQ-028 alpha=31785, ch0 samples 1000, 1000 -> m_data 1000, then 30; each 2 cycles after accept.
REQ-029 ch0 1000, ch1 2000, ch0 1000, ch1 2000 interleaved -> 1000, 2000, 30, 60 with m_ch 0,1,0,1.
REQ-030 ch0 32767 then -32768, alpha=31785 -> second output -32768 with SAT_EN, 984 without.
REQ-031 continuous s_valid, m_ready low for 5 cycles -> s_ready drops once the pipeline is full, m_data held stable, all samples later delivered in order.
REQ-032 ch0 1000 then 1000 with s_sof=1 -> second output 1000; repeat with bypass=1 -> outputs equal inputs.
REQ-033 rst pulsed with 2 samples in flight -> m_valid=0 next cycle; next ch0 1000 -> 1000 (history cleared).
